// File: rtl/avg_pool_filter.sv
// avg_pool_filter: 2x2 stride-2 average pooling of a row-major signed pixel stream (one-row pair-sum buffer).
// Latency: result registered on the edge accepting the window's bottom-right pixel. Define AVG_POOL_ROUND_EN for round-half-up with saturation (default: floor).
// Backpressure: single output register; in_ready = ~out_valid | out_ready, so input stalls only while a result is held.
module avg_pool_filter #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [PIXEL_BIT_WIDTH-1:0] pixel_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic signed [PIXEL_BIT_WIDTH-1:0] pixel_out,
    output logic                              out_valid,
    input  logic                              out_ready
);
    localparam int W        = PIXEL_BIT_WIDTH;
    localparam int OUT_ROWS = IN_ROWS / 2;
    localparam int OUT_COLS = IN_COLS / 2;
    localparam int RW       = $clog2(2 * OUT_ROWS);
    localparam int CW       = $clog2(IN_COLS);
    localparam int LW       = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic signed [W:0]     hsum_q, hsum_d;
    logic signed [W-1:0]   pixel_out_q, pixel_out_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [W:0]     line_buf [OUT_COLS];

    logic                  accept, odd_r, odd_c, last_col, last_row, produce;
    logic [LW-1:0]         lb_idx;
    logic signed [W:0]     pix_ext, pair;
    logic signed [W+1:0]   wsum;
    logic signed [W-1:0]   avg;

    assign in_ready  = ~out_valid_q | out_ready;
    assign pixel_out = pixel_out_q;
    assign out_valid = out_valid_q;

    assign accept   = in_valid & in_ready;
    assign odd_r    = r_q[0];
    assign odd_c    = c_q[0];
    assign last_col = (c_q == CW'(IN_COLS - 1));
    assign last_row = (r_q == RW'(IN_ROWS - 1));
    assign produce  = accept & odd_r & odd_c;
    assign lb_idx   = LW'(c_q >> 1);

    assign pix_ext = {pixel_in[W-1], pixel_in};
    assign pair    = hsum_q + pix_ext;
    assign wsum    = {line_buf[lb_idx][W], line_buf[lb_idx]} + {pair[W], pair};

`ifdef AVG_POOL_ROUND_EN
    logic signed [W+2:0] rsum;
    logic                sat;
    logic [1:0]          unused_frac;

    // One extra bit so a rounded result above the positive limit is detectable.
    assign rsum        = {wsum[W+1], wsum} + (W+3)'(2);
    assign sat         = ~rsum[W+2] & rsum[W+1];
    assign avg         = sat ? {1'b0, {(W-1){1'b1}}} : rsum[W+1:2];
    assign unused_frac = rsum[1:0];
`else
    logic [1:0] unused_frac;

    assign avg         = wsum[W+1:2];
    assign unused_frac = wsum[1:0];
`endif

    always_comb begin
        r_d         = r_q;
        c_d         = c_q;
        hsum_d      = hsum_q;
        pixel_out_d = pixel_out_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (last_col) begin
                c_d = '0;
                r_d = last_row ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
            if (!odd_c) begin
                hsum_d = pix_ext;
            end
            if (produce) begin
                pixel_out_d = avg;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            c_q         <= '0;
            hsum_q      <= '0;
            pixel_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            hsum_q      <= hsum_d;
            pixel_out_q <= pixel_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && !odd_r && odd_c) begin
            line_buf[lb_idx] <= pair;
        end
    end

endmodule

// File: tb/tb_avg_pool_filter.sv
// Bench for avg_pool_filter: table vectors, ramp/random frames under random handshakes,
// back-to-back frames and asynchronous reset mid-frame, checked against an arithmetic model.
module tb_avg_pool_filter;
    localparam int R  = 20;
    localparam int C  = 20;
    localparam int NP = R * C;
    localparam int NO = (R / 2) * (C / 2);

    logic               clk;
    logic               reset;
    logic signed [11:0] pixel_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [11:0] pixel_out;
    logic               out_valid;
    logic               out_ready;

    int errors = 0;
    int checks = 0;
    int stim[$];
    int expq[$];
    int got[$];

    typedef struct {
        int a, b, c, d;
        int exp_floor;
        int exp_round;
    } vec_t;
    vec_t tbl[9];

    avg_pool_filter #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(R), .IN_COLS(C)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(in_ready), .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int pick(input int f, input int r);
`ifdef AVG_POOL_ROUND_EN
        return r;
`else
        return f;
`endif
    endfunction

    // Window average of a 4-pixel sum, straight from the arithmetic definition.
    function automatic int avg4(input int s);
        int v;
`ifdef AVG_POOL_ROUND_EN
        v = s + 2;
`else
        v = s;
`endif
        if (v >= 0) v = v / 4;
        else        v = -((-v + 3) / 4);
`ifdef AVG_POOL_ROUND_EN
        if (v > 2047) v = 2047;
`endif
        return v;
    endfunction

    function automatic void build_model();
        expq.delete();
        for (int f = 0; f < stim.size() / NP; f++)
            for (int wr = 0; wr < R / 2; wr++)
                for (int wc = 0; wc < C / 2; wc++) begin
                    int b;
                    b = f * NP + wr * 2 * C + wc * 2;
                    expq.push_back(avg4(stim[b] + stim[b+1] + stim[b+C] + stim[b+C+1]));
                end
    endfunction

    function automatic void add_ramp();
        for (int i = 0; i < NP; i++) stim.push_back(i);
    endfunction

    function automatic void add_random();
        for (int i = 0; i < NP; i++) stim.push_back(int'($urandom_range(0, 4095)) - 2048);
    endfunction

    task automatic stream(input string tag, input int pv, input int pr);
        int                 idx = 0;
        int                 cyc = 0;
        bit                 hold = 0;
        bit                 acc_in;
        logic signed [11:0] held = '0;
        got.delete();
        while ((idx < stim.size() || got.size() < expq.size()) && cyc < 20000) begin
            in_valid  = (idx < stim.size()) && ($urandom_range(0, 99) < pv);
            pixel_in  = in_valid ? 12'(stim[idx]) : 12'($urandom);
            out_ready = ($urandom_range(0, 99) < pr);
            @(negedge clk);
            check({tag, " in_ready"}, int'(in_ready), int'(!out_valid || out_ready));
            if (hold) begin
                check({tag, " hold valid"}, int'(out_valid), 1);
                check({tag, " hold data"}, int'(pixel_out), int'(held));
            end
            hold   = out_valid && !out_ready;
            held   = pixel_out;
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(int'(pixel_out));
            @(posedge clk);
            #1;
            if (acc_in) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: inputs %0d of %0d, outputs %0d of %0d",
                     tag, idx, stim.size(), got.size(), expq.size());
        end
    endtask

    task automatic compare(input string tag);
        check({tag, " count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], expq[i]);
    endtask

    initial begin
        tbl[0] = '{0, 1, 20, 21, 10, 11};
        tbl[1] = '{-1, -2, -1, -2, -2, -1};
        tbl[2] = '{2047, 2047, 2047, 2047, 2047, 2047};
        tbl[3] = '{-2048, -2048, -2048, -2048, -2048, -2048};
        tbl[4] = '{2047, 2047, 2047, 2046, 2046, 2047};
        tbl[5] = '{-2048, -2048, -2048, -2047, -2048, -2048};
        tbl[6] = '{2, 0, 0, 0, 0, 1};
        tbl[7] = '{-2, 0, 0, 0, -1, 0};
        tbl[8] = '{100, -100, 50, -51, -1, 0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pixel_in  = '0;
        #3;
        check("reset out_valid", int'(out_valid), 0);
        check("reset pixel_out", int'(pixel_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", int'(in_ready), 1);

        // Each vector tiles every 2x2 window of a frame, so all outputs must equal the table value.
        foreach (tbl[k]) begin
            stim.delete();
            expq.delete();
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    int q;
                    q = (r % 2) * 2 + (c % 2);
                    stim.push_back(q == 0 ? tbl[k].a : q == 1 ? tbl[k].b : q == 2 ? tbl[k].c : tbl[k].d);
                end
            for (int i = 0; i < NO; i++) expq.push_back(pick(tbl[k].exp_floor, tbl[k].exp_round));
            stream($sformatf("vec%0d", k), 100, 100);
            compare($sformatf("vec%0d", k));
        end

        stim.delete();
        add_ramp();
        build_model();
        stream("ramp", 100, 100);
        compare("ramp");
        if (got.size() == NO) begin
            check("ramp first", got[0], pick(10, 11));
            check("ramp last", got[NO-1], pick(388, 389));
        end

        stream("ramp bp", 70, 50);
        compare("ramp bp");

        stim.delete();
        add_random();
        build_model();
        stream("random bp", 60, 40);
        compare("random bp");

        stim.delete();
        add_ramp();
        add_ramp();
        build_model();
        stream("b2b", 100, 100);
        compare("b2b");
        if (got.size() == 2 * NO)
            for (int i = 0; i < NO; i++) check($sformatf("b2b repeat[%0d]", i), got[NO+i], got[i]);

        // Reset with an unconsumed result held in the output register.
        stim.delete();
        add_ramp();
        build_model();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 240; i++) begin
            pixel_in = 12'(stim[i]);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pending valid", int'(out_valid), 1);
        check("pending data", int'(pixel_out), expq[59]);
        #2;
        reset = 1'b0;
        #1;
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst pixel_out", int'(pixel_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst release in_ready", int'(in_ready), 1);
        stream("after rst", 80, 80);
        compare("after rst");
        repeat (4) @(posedge clk);
        #1;
        check("idle out_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
